// File: rtl/wb_ram_slave_pkg.sv
// rtl/wb_ram_slave_pkg.sv - shared Wishbone bus widths
package wb_ram_slave_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = WB_DATA_W / 8;

endpackage

// File: rtl/wb_ram_array.sv
// rtl/wb_ram_array.sv - single-port RAM, per-byte write enables, registered read
module wb_ram_array
  import wb_ram_slave_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic                 rd_en,
  input  logic [WB_SEL_W-1:0]  wr_be,
  input  logic [IDX_W-1:0]     idx,
  input  logic [WB_DATA_W-1:0] wdata,
  output logic [WB_DATA_W-1:0] rdata
);

  logic [WB_DATA_W-1:0] mem [DEPTH];

  // Byte-lane writes; the array itself is never reset so it maps onto block RAM.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < WB_SEL_W; i++) begin
      if (wr_be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  // Output register only moves on a read, so it holds the last read word.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in)  rdata <= '0;
    else if (rd_en) rdata <= mem[idx];
  end

endmodule

// File: rtl/wb_ram_slave.sv
// rtl/wb_ram_slave.sv - Wishbone B4 classic RAM slave with wait states and error response
module wb_ram_slave
  import wb_ram_slave_pkg::*;
#(
  parameter int                   DEPTH_WORDS = 1024,
  parameter logic [WB_ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int                   WAIT_STATES = 0
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic                 wb_cyc_in,
  input  logic                 wb_stb_in,
  input  logic                 wb_we_in,
  input  logic [WB_ADDR_W-1:0] wb_adr_in,
  input  logic [WB_DATA_W-1:0] wb_dat_in,
  input  logic [WB_SEL_W-1:0]  wb_sel_in,
  output logic [WB_DATA_W-1:0] wb_dat_out,
  output logic                 wb_ack_out,
  output logic                 wb_err_out
);

  localparam int         IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 capture;
  logic [IDX_W-1:0]     idx_q;
  logic                 we_q, bad_q;
  logic [WB_DATA_W-1:0] dat_q;
  logic [WB_SEL_W-1:0]  sel_q;

  // Decode straight off the bus; the window is a power of two and aligned, so
  // "in range" means every offset bit above the index is zero.
  logic [WB_ADDR_W-1:0] offset;
  logic [IDX_W-1:0]     bus_idx;
  logic                 bus_bad;

  assign offset  = wb_adr_in - BASE_ADDR;
  assign bus_idx = offset[IDX_W+1:2];
  assign bus_bad = (offset[WB_ADDR_W-1:IDX_W+2] != '0) || (offset[1:0] != 2'b00);

  // RAM port: "fire" marks the edge that enters RESP, where the access happens.
  logic                 fire, f_we, f_bad;
  logic [IDX_W-1:0]     f_idx;
  logic [WB_DATA_W-1:0] f_dat;
  logic [WB_SEL_W-1:0]  f_sel;
  logic                 ram_rd;
  logic [WB_SEL_W-1:0]  ram_be;

  // State and wait counter.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request latch, so the master only has to hold its signals at the accepting edge.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      idx_q <= '0;
      we_q  <= 1'b0;
      bad_q <= 1'b0;
      dat_q <= '0;
      sel_q <= '0;
    end else if (capture) begin
      idx_q <= bus_idx;
      we_q  <= wb_we_in;
      bad_q <= bus_bad;
      dat_q <= wb_dat_in;
      sel_q <= wb_sel_in;
    end
  end

  // Next state, RAM access and the response pulse.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    capture    = 1'b0;
    wb_ack_out = 1'b0;
    wb_err_out = 1'b0;
    fire       = 1'b0;
    f_idx      = idx_q;
    f_we       = we_q;
    f_bad      = bad_q;
    f_dat      = dat_q;
    f_sel      = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (wb_cyc_in && wb_stb_in) begin
          capture = 1'b1;
          if (WAIT_STATES == 0) begin
            // No wait states: the access must use the live bus fields this edge.
            state_d = ST_RESP;
            fire    = 1'b1;
            f_idx   = bus_idx;
            f_we    = wb_we_in;
            f_bad   = bus_bad;
            f_dat   = wb_dat_in;
            f_sel   = wb_sel_in;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WS_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (!wb_cyc_in) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          fire    = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        wb_ack_out = !bad_q;
        wb_err_out = bad_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    ram_rd = fire && !f_bad && !f_we;
    ram_be = (fire && !f_bad && f_we) ? f_sel : '0;
  end

  wb_ram_array #(
    .DEPTH (DEPTH_WORDS),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .rd_en    (ram_rd),
    .wr_be    (ram_be),
    .idx      (f_idx),
    .wdata    (f_dat),
    .rdata    (wb_dat_out)
  );

endmodule

// File: tb/tb_wb_ram_slave.sv
// tb/tb_wb_ram_slave.sv - directed self-checking bench for wb_ram_slave
module tb_wb_ram_slave;

  logic        clk_in = 1'b0;
  logic        reset_n;
  logic        we;
  logic [31:0] adr, wdat;
  logic [3:0]  sel;
  logic        cyc0, stb0, cyc3, stb3;
  logic [31:0] dat0, dat3;
  logic        ack0, err0, ack3, err3;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk_in = ~clk_in;

  wb_ram_slave #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(0)) dut0 (
    .clk_in(clk_in), .reset_in(reset_n), .wb_cyc_in(cyc0), .wb_stb_in(stb0),
    .wb_we_in(we), .wb_adr_in(adr), .wb_dat_in(wdat), .wb_sel_in(sel),
    .wb_dat_out(dat0), .wb_ack_out(ack0), .wb_err_out(err0)
  );

  wb_ram_slave #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(3)) dut3 (
    .clk_in(clk_in), .reset_in(reset_n), .wb_cyc_in(cyc3), .wb_stb_in(stb3),
    .wb_we_in(we), .wb_adr_in(adr), .wb_dat_in(wdat), .wb_sel_in(sel),
    .wb_dat_out(dat3), .wb_ack_out(ack3), .wb_err_out(err3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Single transfer on the zero-wait slave; response expected in the cycle after acceptance.
  task automatic tx0(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic exp_err, input logic [31:0] exp_dat);
    we = w; adr = a; wdat = d; sel = s; cyc0 = 1'b1; stb0 = 1'b1;
    @(posedge clk_in); #1;
    chk({tag, ".resp"}, 32'({ack0, err0}), exp_err ? 32'd1 : 32'd2);
    chk({tag, ".dat"}, dat0, exp_dat);
    cyc0 = 1'b0; stb0 = 1'b0;
    @(posedge clk_in); #1;
    chk({tag, ".end"}, 32'({ack0, err0}), 32'd0);
  endtask

  // Single transfer on the 3-wait slave; counts cycles from the accepting edge to the response.
  task automatic tx3(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic exp_err, input logic [31:0] exp_dat);
    int n = 0;
    logic got = 1'b0;
    we = w; adr = a; wdat = d; sel = s; cyc3 = 1'b1; stb3 = 1'b1;
    while (!got && n < 20) begin
      @(posedge clk_in); #1;
      n++;
      if (n == 1) stb3 = 1'b0;
      if (ack3 || err3) got = 1'b1;
    end
    chk({tag, ".lat"}, 32'(n), 32'd4);
    chk({tag, ".resp"}, 32'({ack3, err3}), exp_err ? 32'd1 : 32'd2);
    chk({tag, ".dat"}, dat3, exp_dat);
    cyc3 = 1'b0;
    @(posedge clk_in); #1;
    chk({tag, ".end"}, 32'({ack3, err3}), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] mask;
    logic        seen;
    reset_n = 1'b1;
    we = 1'b0; adr = '0; wdat = '0; sel = '0;
    cyc0 = 1'b0; stb0 = 1'b0; cyc3 = 1'b0; stb3 = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("rst.resp0", 32'({ack0, err0}), 32'd0);
    chk("rst.dat0", dat0, 32'h0);
    chk("rst.resp3", 32'({ack3, err3}), 32'd0);
    chk("rst.dat3", dat3, 32'h0);
    repeat (3) @(posedge clk_in);
    #1 reset_n = 1'b1;
    @(posedge clk_in); #1;

    // Zero-wait slave: basic access, byte lanes, decode errors.
    tx0("w_dead",  1'b1, 32'h0000_1008, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0000_0000);
    tx0("r_dead",  1'b0, 32'h0000_1008, 32'h0000_0000, 4'hF, 1'b0, 32'hDEAD_BEEF);
    tx0("w_aabb",  1'b1, 32'h0000_100C, 32'hAABB_CCDD, 4'hF, 1'b0, 32'hDEAD_BEEF);
    tx0("w_lanes", 1'b1, 32'h0000_100C, 32'h1122_3344, 4'b0101, 1'b0, 32'hDEAD_BEEF);
    tx0("r_lanes", 1'b0, 32'h0000_100C, 32'h0000_0000, 4'hF, 1'b0, 32'hAA22_CC44);
    tx0("w_sel0",  1'b1, 32'h0000_100C, 32'h0000_0000, 4'h0, 1'b0, 32'hAA22_CC44);
    tx0("r_sel0",  1'b0, 32'h0000_100C, 32'h0000_0000, 4'h0, 1'b0, 32'hAA22_CC44);
    tx0("w_word0", 1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF, 1'b0, 32'hAA22_CC44);
    tx0("r_oor",   1'b0, 32'h0000_1040, 32'h0000_0000, 4'hF, 1'b1, 32'hAA22_CC44);
    tx0("w_oor",   1'b1, 32'h0000_1040, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'hAA22_CC44);
    tx0("w_misal", 1'b1, 32'h0000_1002, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'hAA22_CC44);
    tx0("r_below", 1'b0, 32'h0000_0FFC, 32'h0000_0000, 4'hF, 1'b1, 32'hAA22_CC44);
    tx0("r_word0", 1'b0, 32'h0000_1000, 32'h0000_0000, 4'hF, 1'b0, 32'h1234_5678);

    // Zero-wait back-to-back: acks in cycles 1, 3, 5 after the first accepting edge.
    we = 1'b0; adr = 32'h0000_1008; cyc0 = 1'b1; stb0 = 1'b1; mask = '0;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk_in); #1;
      mask[n-1] = ack0 | err0;
    end
    cyc0 = 1'b0; stb0 = 1'b0;
    chk("b2b0.mask", 32'(mask), 32'h0000_0015);
    chk("b2b0.dat", dat0, 32'hDEAD_BEEF);
    @(posedge clk_in); #1;

    // Three-wait slave: latency, error, back-to-back, abort, async reset.
    tx3("w3_cafe", 1'b1, 32'h0000_1010, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0000_0000);
    tx3("r3_cafe", 1'b0, 32'h0000_1010, 32'h0000_0000, 4'hF, 1'b0, 32'hCAFE_F00D);
    tx3("r3_misal", 1'b0, 32'h0000_1002, 32'h0000_0000, 4'hF, 1'b1, 32'hCAFE_F00D);

    we = 1'b0; adr = 32'h0000_1010; cyc3 = 1'b1; stb3 = 1'b1; mask = '0;
    for (int n = 1; n <= 15; n++) begin
      @(posedge clk_in); #1;
      mask[n-1] = ack3 | err3;
    end
    cyc3 = 1'b0; stb3 = 1'b0;
    chk("b2b3.mask", 32'(mask), 32'h0000_2108);
    chk("b2b3.dat", dat3, 32'hCAFE_F00D);
    @(posedge clk_in); #1;

    we = 1'b1; adr = 32'h0000_1010; wdat = 32'hBAD0_BAD0; sel = 4'hF;
    cyc3 = 1'b1; stb3 = 1'b1; seen = 1'b0;
    @(posedge clk_in); #1;
    seen |= ack3 | err3;
    stb3 = 1'b0;
    @(posedge clk_in); #1;
    seen |= ack3 | err3;
    cyc3 = 1'b0;
    repeat (4) begin
      @(posedge clk_in); #1;
      seen |= ack3 | err3;
    end
    chk("abort.resp", 32'(seen), 32'd0);
    tx3("r3_abort", 1'b0, 32'h0000_1010, 32'h0000_0000, 4'hF, 1'b0, 32'hCAFE_F00D);

    we = 1'b1; adr = 32'h0000_1010; wdat = 32'h0BAD_F00D; sel = 4'hF;
    cyc3 = 1'b1; stb3 = 1'b1;
    @(posedge clk_in); #1;
    stb3 = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("rstw.resp3", 32'({ack3, err3}), 32'd0);
    chk("rstw.dat3", dat3, 32'h0);
    chk("rstw.dat0", dat0, 32'h0);
    cyc3 = 1'b0;
    @(posedge clk_in);
    @(posedge clk_in); #1;
    reset_n = 1'b1;
    @(posedge clk_in); #1;
    chk("rstw.hold3", dat3, 32'h0);
    tx3("r3_rst", 1'b0, 32'h0000_1010, 32'h0000_0000, 4'hF, 1'b0, 32'hCAFE_F00D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
